// File: rtl/shift_right_seq_pkg.sv
// Shared encodings for the iterative right shifter and the control unit that drives it.
// FSM state codes and the MIPS funct codes that select SRL vs SRA.
package shift_right_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [5:0] FUNCT_SRL = 6'h02;
  localparam logic [5:0] FUNCT_SRA = 6'h03;

  // The control unit drives the shifter's arith input from this decode.
  function automatic logic funct_is_arith(input logic [5:0] funct);
    return (funct == FUNCT_SRA);
  endfunction

endpackage

// File: rtl/shift_right_seq_shr1_step.sv
// Combinational single-bit right shift with an explicit fill bit for the vacated MSB.
// Zero latency; no handshake, purely combinational.
module shr1_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d,
  input  logic             fill,
  output logic [WIDTH-1:0] q
);

  assign q = (d >> 1) | {fill, {(WIDTH-1){1'b0}}};

endmodule

// File: rtl/shift_right_seq.sv
// Iterative SRL/SRA: one bit per clock through a single shr1_step stage.
// Latency shamt+1 cycles to the done pulse; start is ignored while busy, nothing is queued.
module shift_right_seq
  import shift_right_seq_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic [WIDTH-1:0]   out,
  output logic               busy,
  output logic               done
);

  localparam logic [SHAMT_W-1:0] ONE = SHAMT_W'(1);

  state_t             state, state_nxt;
  logic [SHAMT_W-1:0] count;
  logic               mode;
  logic               sign;
  logic               fill;
  logic [WIDTH-1:0]   step_q;

  // Fill comes from the sign captured at accept, not from the evolving out MSB.
  assign fill = mode & sign;

  shr1_step #(.WIDTH(WIDTH)) u_step (
    .d    (out),
    .fill (fill),
    .q    (step_q)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
      out   <= '0;
      count <= '0;
      mode  <= 1'b0;
      sign  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (start) begin
            out   <= in;
            count <= shamt;
            mode  <= arith;
            sign  <= in[WIDTH-1];
          end
        end
        ST_SHIFT: begin
          out   <= step_q;
          count <= count - ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = (shamt == '0) ? ST_DONE : ST_SHIFT;
      ST_SHIFT: if (count == ONE) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

endmodule

// File: doc/shift_right_seq.md
Name: shift_right_seq

Overview:
- Iterative right shifter. Counterpart to the datapath's combinational left shift.
- Implements MIPS SRL/SRA (logical and arithmetic right shift) one bit per clock.
- Uses a start/busy/done handshake; sits beside the ALU under control-unit sequencing.
- Trades latency for area: one 1-bit shift stage instead of a 32-bit barrel.

Parameters:
- WIDTH, 32, data width in bits.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; sampled only when busy=0.
- in  input  WIDTH  operand to shift (latched on accept).
- shamt  input  SHAMT_W  shift amount 0..WIDTH-1 (latched on accept).
- arith  input  1  1 = SRA (sign fill), 0 = SRL (zero fill); latched on accept.
- out  output  WIDTH  shift result register; valid when done=1, held until next accept.
- busy  output  1  high whenever state != IDLE.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset (sampled on a clk edge):
  - state=IDLE, out=0, busy=0, done=0, internal count=0.
  - Reset overrides start.
  - Reset during SHIFT or DONE aborts the operation. No done pulse is issued.
- States:
  - IDLE: waiting for a request.
  - SHIFT: iterating.
  - DONE: result presented.
- IDLE, start=1 (accept edge E0):
  - Latch in into out, shamt into count, arith into a mode flag.
  - Capture sign = in[WIDTH-1].
  - If shamt=0, go to DONE; otherwise go to SHIFT.
- SHIFT, each edge:
  - out <= {fill, out[WIDTH-1:1]}, with fill = mode ? sign : 0.
  - count <= count-1.
  - The edge on which count==1 performs the final shift and goes to DONE.
- DONE:
  - done=1 for exactly one cycle.
  - Next edge returns to IDLE unconditionally.
  - start is ignored in DONE.
- Latency: done is high in the cycle after edge E0+shamt. That is 1 cycle for shamt=0 and shamt+1 cycles in general; maximum 32 cycles.
- busy: 1 in SHIFT and DONE, 0 in IDLE. Any start while busy=1 is ignored; nothing is queued.
- Operand isolation: in, shamt and arith may change freely after accept without affecting the result.
- out retention: holds the final result through DONE and IDLE until the next accept overwrites it. During SHIFT, out shows intermediate values that the consumer must not use.
- Arithmetic fill: always uses the latched sign bit, never the current out[WIDTH-1].
- Result equivalence: must match in >> shamt (SRL) or $signed(in) >>> shamt (SRA) for all inputs.

Decomposition:
- Shared defines/include file:
  - State encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2.
  - Funct codes FUNCT_SRL=6'h02, FUNCT_SRA=6'h03, so the control unit derives arith from the same constants.
- Sub-module: shr1_step, a combinational 1-bit shift with fill input (WIDTH in, fill in, WIDTH out). It is instantiated once in the SHIFT datapath and reused by the bench's reference model.

Test Plan:
1. Reset asserted 2 cycles, no start -> out=0x00000000, busy=0, done=0. A start pulse asserted together with reset is not accepted.
2. in=0x80000000, shamt=4, arith=0, start 1 cycle -> busy=1 next cycle; done=1 exactly 5 cycles after accept edge; out=0x08000000; busy=0 one cycle later.
3. Same as 2 with arith=1 -> out=0xF8000000 with identical timing. Then in=0x7FFFFFF0, shamt=4, arith=1 -> out=0x07FFFFFF.
4. in=0x12345678, shamt=0, arith=1 -> done=1 on cycle after accept, out=0x12345678. Then shamt=31, in=0x80000000, arith=1 -> out=0xFFFFFFFF after 32 cycles. During that op, pulse start with in=0xDEADBEEF at cycles 3 and 10, and change in/shamt -> both ignored, result unchanged.
5. Start in=0xFFFF0000, shamt=10, arith=0; assert reset on 4th cycle after accept -> next edge: busy=0, done=0, out=0; no done pulse ever. A subsequent start of in=0x00000100, shamt=8 -> out=0x00000001.
6. Randomized: 1000 back-to-back ops (start asserted on every cycle busy=0) with random in, shamt, arith -> every done pulse matches the shr1_step-based reference model. Latency is shamt+1 in every op, and no done is missed or duplicated.
